// File: rtl/logic2_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic2_pipe
//  Description : Pipelined two-operand bitwise logic unit (AND/OR/XOR/NAND)
//                with valid/ready handshaking, bubble absorption and a
//                saturating delivered-result counter.
//  Revision    : 1.0  initial release
// ============================================================================
module logic2_pipe #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] result_cnt
);

    localparam logic [1:0]       c_OP_AND  = 2'b00;
    localparam logic [1:0]       c_OP_OR   = 2'b01;
    localparam logic [1:0]       c_OP_XOR  = 2'b10;
    localparam int               c_LAST    = STAGES - 1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [WIDTH-1:0]  w_result;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [CNT_W-1:0]  r_cnt;
    logic              w_deliver;

    // Selected bitwise operation on the incoming operands.
    always_comb begin
        w_result = '0;
        case (op)
            c_OP_AND: w_result = a & b;
            c_OP_OR:  w_result = a | b;
            c_OP_XOR: w_result = a ^ b;
            default:  w_result = ~(a & b);
        endcase
    end

    // Advance chain: a stage moves when it is empty or its successor moves;
    // evaluated from the output end backwards so bubbles collapse under stall.
    always_comb begin
        w_adv         = '0;
        w_adv[c_LAST] = out_ready || !r_valid[c_LAST];
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = !r_valid[k] || w_adv[k+1];
        end
    end

    assign in_ready  = w_adv[0] && !reset;
    assign c         = r_data[c_LAST];
    assign out_valid = r_valid[c_LAST];
    assign w_deliver = r_valid[c_LAST] && out_ready;

    // Stage registers: data only moves with a valid beat so c stays stable
    // while empty; valid bits drop when a beat leaves with nothing behind it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= w_result;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_data[k] <= r_data[k-1];
                    end
                end
            end
        end
    end

    // Delivered-result counter, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_deliver && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign result_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic2_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic2_pipe
//  Description : Directed self-checking bench for logic2_pipe (WIDTH=2,
//                STAGES=2); a second instance with CNT_W=3 shares the
//                stimulus to exercise counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_logic2_pipe;

    localparam int W = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  a, b;
    logic [1:0]    op;
    logic          in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [W-1:0]  c;
    logic [15:0]   result_cnt;
    logic          s_in_ready, s_out_valid;
    logic [W-1:0]  s_c;
    logic [2:0]    s_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic2_pipe #(.WIDTH(W), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .c(c),
        .out_valid(out_valid), .out_ready(out_ready), .result_cnt(result_cnt)
    );

    logic2_pipe #(.WIDTH(W), .STAGES(2), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(s_in_ready), .c(s_c),
        .out_valid(s_out_valid), .out_ready(out_ready), .result_cnt(s_cnt)
    );

    function automatic logic [1:0] f_op(input logic [1:0] x, input logic [1:0] y,
                                        input logic [1:0] o);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom); b = W'($urandom); op = 2'($urandom);
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            #5;
            n_vec++; if (c !== 2'b00) begin n_err++; $display("FAIL rst_hold_c got=%b exp=00", c); end
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_ov got=%b exp=0", out_valid); end
            n_vec++; if (in_ready !== 1'b0 || s_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_hold_ir got=%b/%b exp=0", in_ready, s_in_ready); end
            n_vec++; if (result_cnt !== 16'd0 || s_cnt !== 3'd0 || s_c !== 2'b00) begin n_err++; $display("FAIL rst_hold_cnt got=%0d/%0d exp=0", result_cnt, s_cnt); end
            #5;
        end
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_ops();
        logic [1:0] exp_c [4];
        exp_c[0] = 2'b01; exp_c[1] = 2'b11; exp_c[2] = 2'b10; exp_c[3] = 2'b10;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 2'b01; b = 2'b11; op = 2'(i); in_valid = 1'b1;
            #1;
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ops_in_ready op=%0d got=%b exp=1", i, in_ready); end
            tick();
            in_valid = 1'b0;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ops_early op=%0d out_valid got=%b exp=0", i, out_valid); end
            tick();
            n_vec++; if (out_valid !== 1'b1 || c !== exp_c[i]) begin n_err++; $display("FAIL ops_result op=%0d got=%b/%b exp=1/%b", i, out_valid, c, exp_c[i]); end
        end
        tick();
        n_vec++; if (result_cnt !== 16'd4) begin n_err++; $display("FAIL ops_cnt got=%0d exp=4", result_cnt); end
    endtask

    task automatic test_backpressure();
        logic [1:0] va [6], vb [6], vo [6], ve [6];
        int tx, rx, cyc;
        logic acc, dlv;
        va[0]=2'b01; vb[0]=2'b10; vo[0]=2'b01; ve[0]=2'b11;
        va[1]=2'b11; vb[1]=2'b10; vo[1]=2'b00; ve[1]=2'b10;
        va[2]=2'b11; vb[2]=2'b01; vo[2]=2'b10; ve[2]=2'b10;
        va[3]=2'b00; vb[3]=2'b00; vo[3]=2'b11; ve[3]=2'b11;
        va[4]=2'b10; vb[4]=2'b11; vo[4]=2'b00; ve[4]=2'b10;
        va[5]=2'b01; vb[5]=2'b01; vo[5]=2'b10; ve[5]=2'b00;
        do_reset();
        tx = 0; rx = 0; cyc = 0;
        while (rx < 6 && cyc < 40) begin
            out_ready = (cyc >= 4);
            in_valid  = (tx < 6);
            if (tx < 6) begin a = va[tx]; b = vb[tx]; op = vo[tx]; end
            #1;
            if (cyc == 1) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_second_accept got=%b exp=1", in_ready); end
            end
            if (cyc == 2 || cyc == 3) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                n_vec++; if (out_valid !== 1'b1 || c !== ve[0]) begin n_err++; $display("FAIL bp_hold cyc=%0d got=%b/%b exp=1/%b", cyc, out_valid, c, ve[0]); end
            end
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (dlv) begin
                n_vec++; if (c !== ve[rx]) begin n_err++; $display("FAIL bp_order idx=%0d got=%b exp=%b", rx, c, ve[rx]); end
                rx++;
            end
            tick();
            if (acc) tx++;
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++; if (rx != 6) begin n_err++; $display("FAIL bp_timeout delivered=%0d exp=6", rx); end
        n_vec++; if (result_cnt !== 16'd6) begin n_err++; $display("FAIL bp_cnt got=%0d exp=6", result_cnt); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_throughput();
        logic [1:0] ka, kb, ko;
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            in_valid = (cyc < 20);
            a = 2'(cyc); b = 2'(cyc >> 2); op = 2'(cyc >> 1);
            #1;
            if (cyc < 20) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL tp_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
            end
            n_vec++; if (out_valid !== (cyc >= 2 && cyc < 22)) begin n_err++; $display("FAIL tp_out_valid cyc=%0d got=%b", cyc, out_valid); end
            if (cyc >= 2 && cyc < 22) begin
                ka = 2'(cyc - 2); kb = 2'((cyc - 2) >> 2); ko = 2'((cyc - 2) >> 1);
                n_vec++; if (c !== f_op(ka, kb, ko)) begin n_err++; $display("FAIL tp_data cyc=%0d got=%b exp=%b", cyc, c, f_op(ka, kb, ko)); end
            end
            tick();
        end
        in_valid = 1'b0;
        n_vec++; if (result_cnt !== 16'd20) begin n_err++; $display("FAIL tp_cnt got=%0d exp=20", result_cnt); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        a = 2'b11; b = 2'b11; op = 2'b00; in_valid = 1'b1;
        tick();
        a = 2'b10; b = 2'b11; op = 2'b01;
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_inflight out_valid got=%b exp=1", out_valid); end
        #3;
        reset = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || c !== 2'b00) begin n_err++; $display("FAIL mid_async got=%b/%b exp=0/00", out_valid, c); end
        n_vec++; if (in_ready !== 1'b0 || result_cnt !== 16'd0) begin n_err++; $display("FAIL mid_async_ir got=%b/%0d exp=0/0", in_ready, result_cnt); end
        tick(); tick();
        reset = 1'b0;
        out_ready = 1'b1;
        a = 2'b10; b = 2'b01; op = 2'b01; in_valid = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_first_accept got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale out_valid got=%b exp=0", out_valid); end
        tick();
        n_vec++; if (out_valid !== 1'b1 || c !== 2'b11) begin n_err++; $display("FAIL mid_new got=%b/%b exp=1/11", out_valid, c); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_after step=%0d out_valid got=%b exp=0", i, out_valid); end
        end
        n_vec++; if (result_cnt !== 16'd1) begin n_err++; $display("FAIL mid_cnt got=%0d exp=1", result_cnt); end
    endtask

    task automatic test_saturation();
        int delivered;
        logic [2:0] exp_sat;
        do_reset();
        out_ready = 1'b1;
        delivered = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            in_valid = (cyc < 10);
            a = 2'(cyc); b = 2'b10; op = 2'b10;
            #1;
            n_vec++; if (s_out_valid !== (cyc >= 2 && cyc < 12)) begin n_err++; $display("FAIL sat_ov cyc=%0d got=%b", cyc, s_out_valid); end
            tick();
            if (cyc >= 2 && cyc < 12) delivered++;
            exp_sat = (delivered > 7) ? 3'd7 : 3'(delivered);
            n_vec++; if (s_cnt !== exp_sat) begin n_err++; $display("FAIL sat_step cyc=%0d got=%0d exp=%0d", cyc, s_cnt, exp_sat); end
        end
        in_valid = 1'b0;
        n_vec++; if (s_cnt !== 3'd7) begin n_err++; $display("FAIL sat_final got=%0d exp=7", s_cnt); end
        n_vec++; if (result_cnt !== 16'd10) begin n_err++; $display("FAIL sat_wide_cnt got=%0d exp=10", result_cnt); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        test_reset();
        test_ops();
        test_backpressure();
        test_throughput();
        test_reset_midstream();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
